// File: rtl/shift_reg_universal_if.sv
// Command/status bundle for shift_reg_universal: control and data in, register state out.
interface shift_reg_universal_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [2:0]       mode;
  logic             sin;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, sin, d,
    input  q, sout, busy, done
  );

  modport slave (
    input  en, mode, sin, d,
    output q, sout, busy, done
  );
endinterface

// File: rtl/shift_reg_universal.sv
// Universal WIDTH-bit register: hold/shift/rotate/load/clear plus an LSB-first
// auto-serialise sequence run by a two-state FSM.
module shift_reg_universal #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic                  clk,
  input logic                  rst,
  shift_reg_universal_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SER  = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] q_r, q_s;
  logic             sout_r, sout_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [CW-1:0]    cnt_r, cnt_s;

  // Next-state and datapath decode; done defaults low so it can only pulse once.
  always_comb begin
    state_s = state_r;
    q_s     = q_r;
    sout_s  = sout_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    cnt_s   = cnt_r;
    if (bus.en) begin
      case (state_r)
        IDLE: begin
          case (bus.mode)
            3'b000: begin
              q_s = q_r;
            end
            3'b001: begin
              q_s    = {q_r[WIDTH-2:0], bus.sin};
              sout_s = q_r[WIDTH-1];
            end
            3'b010: begin
              q_s    = {bus.sin, q_r[WIDTH-1:1]};
              sout_s = q_r[0];
            end
            3'b011: begin
              q_s    = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
              sout_s = q_r[WIDTH-1];
            end
            3'b100: begin
              q_s    = {q_r[0], q_r[WIDTH-1:1]};
              sout_s = q_r[0];
            end
            3'b101: begin
              q_s = bus.d;
            end
            3'b110: begin
              q_s     = bus.d;
              cnt_s   = {CW{1'b0}};
              busy_s  = 1'b1;
              state_s = SER;
            end
            3'b111: begin
              q_s    = RST_VAL;
              sout_s = 1'b0;
            end
            default: begin
              q_s = q_r;
            end
          endcase
        end
        SER: begin
          // Zero-fill shift toward the LSB; sin, mode and d are ignored here.
          sout_s = q_r[0];
          q_s    = {1'b0, q_r[WIDTH-1:1]};
          if (cnt_r == CW'(WIDTH - 1)) begin
            cnt_s   = {CW{1'b0}};
            busy_s  = 1'b0;
            done_s  = 1'b1;
            state_s = IDLE;
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end
        default: begin
          state_s = IDLE;
          busy_s  = 1'b0;
          cnt_s   = {CW{1'b0}};
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers with immediate reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      q_r     <= RST_VAL;
      sout_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_s;
      q_r     <= q_s;
      sout_r  <= sout_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      cnt_r   <= cnt_s;
    end
  end

  assign bus.q    = q_r;
  assign bus.sout = sout_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_shift_reg_universal.sv
// Directed-vector bench for shift_reg_universal (WIDTH=8, RST_VAL=0).
module tb_shift_reg_universal;

  logic clk;
  logic rst;
  logic run;
  int   vec_cnt;
  int   err_cnt;

  shift_reg_universal_if #(.WIDTH(8)) bus ();

  shift_reg_universal #(.WIDTH(8), .RST_VAL(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (run) clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired, observed running, required finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one command, let one posedge happen, return at the following negedge.
  task automatic step(input logic e, input logic [2:0] m, input logic s, input logic [7:0] dv);
    bus.en   = e;
    bus.mode = m;
    bus.sin  = s;
    bus.d    = dv;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] ser_d;
    vec_cnt  = 0;
    err_cnt  = 0;
    run      = 1'b0;
    rst      = 1'b1;
    bus.en   = 1'b0;
    bus.mode = 3'b000;
    bus.sin  = 1'b0;
    bus.d    = 8'h00;
    ser_d    = 8'b1011_0010;

    #2;
    check_eq("rst_q", 32'(bus.q), 32'h00);
    check_eq("rst_sout", 32'(bus.sout), 32'h0);
    check_eq("rst_busy", 32'(bus.busy), 32'h0);
    check_eq("rst_done", 32'(bus.done), 32'h0);

    run = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'b000, 1'b1, 8'hFF);
      check_eq("idle_hold_q", 32'(bus.q), 32'h00);
      check_eq("idle_hold_busy", 32'(bus.busy), 32'h0);
    end

    step(1'b1, 3'b101, 1'b0, 8'hA5);
    check_eq("load_q", 32'(bus.q), 32'hA5);
    step(1'b1, 3'b001, 1'b1, 8'h00);
    check_eq("shl_q", 32'(bus.q), 32'h4B);
    check_eq("shl_sout", 32'(bus.sout), 32'h1);
    step(1'b1, 3'b100, 1'b0, 8'h00);
    check_eq("rotr_q", 32'(bus.q), 32'hA5);
    check_eq("rotr_sout", 32'(bus.sout), 32'h1);
    step(1'b1, 3'b010, 1'b0, 8'h00);
    check_eq("shr_q", 32'(bus.q), 32'h52);
    check_eq("shr_sout", 32'(bus.sout), 32'h1);
    step(1'b1, 3'b101, 1'b0, 8'h81);
    step(1'b1, 3'b011, 1'b0, 8'h00);
    check_eq("rotl_q", 32'(bus.q), 32'h03);
    check_eq("rotl_sout", 32'(bus.sout), 32'h1);

    step(1'b1, 3'b101, 1'b0, 8'h3C);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 3'b001, 1'b1, 8'h00);
      check_eq("en_gate_q", 32'(bus.q), 32'h3C);
    end
    step(1'b1, 3'b001, 1'b0, 8'h00);
    check_eq("en_shl_q", 32'(bus.q), 32'h78);
    check_eq("en_shl_sout", 32'(bus.sout), 32'h0);
    step(1'b1, 3'b001, 1'b1, 8'h00);
    step(1'b1, 3'b111, 1'b1, 8'hFF);
    check_eq("clr_q", 32'(bus.q), 32'h00);
    check_eq("clr_sout", 32'(bus.sout), 32'h0);

    // Unstalled auto-serialise.
    step(1'b1, 3'b110, 1'b0, ser_d);
    check_eq("ser_load_q", 32'(bus.q), 32'hB2);
    check_eq("ser_load_busy", 32'(bus.busy), 32'h1);
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 3'b000, 1'b1, 8'h00);
      check_eq("ser_sout", 32'(bus.sout), 32'(ser_d[k-1]));
      check_eq("ser_busy", 32'(bus.busy), (k < 8) ? 32'h1 : 32'h0);
      check_eq("ser_done", 32'(bus.done), (k < 8) ? 32'h0 : 32'h1);
    end
    check_eq("ser_end_q", 32'(bus.q), 32'h00);
    step(1'b1, 3'b000, 1'b0, 8'h00);
    check_eq("ser_done_drop", 32'(bus.done), 32'h0);

    // Stalled serialise with ignored mid-SER load command.
    step(1'b1, 3'b110, 1'b0, ser_d);
    for (int k = 1; k <= 3; k++) step(1'b1, 3'b000, 1'b0, 8'h00);
    check_eq("stall_pre_sout", 32'(bus.sout), 32'h0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 3'b101, 1'b1, 8'hFF);
      check_eq("stall_q", 32'(bus.q), 32'h16);
      check_eq("stall_sout", 32'(bus.sout), 32'h0);
      check_eq("stall_busy", 32'(bus.busy), 32'h1);
      check_eq("stall_done", 32'(bus.done), 32'h0);
    end
    for (int k = 4; k <= 8; k++) begin
      step(1'b1, 3'b101, 1'b1, 8'hFF);
      check_eq("stall_ser_sout", 32'(bus.sout), 32'(ser_d[k-1]));
      check_eq("stall_ser_done", 32'(bus.done), (k < 8) ? 32'h0 : 32'h1);
    end
    check_eq("stall_end_q", 32'(bus.q), 32'h00);
    step(1'b1, 3'b000, 1'b0, 8'h00);

    // Reset between edges 4 and 5.
    step(1'b1, 3'b110, 1'b0, ser_d);
    for (int k = 1; k <= 4; k++) step(1'b1, 3'b000, 1'b0, 8'h00);
    check_eq("mid_pre_busy", 32'(bus.busy), 32'h1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_q", 32'(bus.q), 32'h00);
    check_eq("mid_rst_busy", 32'(bus.busy), 32'h0);
    check_eq("mid_rst_done", 32'(bus.done), 32'h0);
    check_eq("mid_rst_sout", 32'(bus.sout), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 3'b101, 1'b0, 8'h0F);
    check_eq("post_rst_load_q", 32'(bus.q), 32'h0F);
    check_eq("post_rst_busy", 32'(bus.busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
